// File: rtl/reg_file_16x16.sv
// 16 x DATA_WIDTH architectural register file: one write port, two combinational read ports.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.

module reg_file_16x16_wr_dec (
    input  logic [3:0]  dst_reg,
    input  logic        write_reg,
    output logic [15:0] wordline
);

    // One-hot wordline; all-zero without a request so an unknown dst_reg cannot leak through
    always_comb begin
        wordline = 16'h0000;
        if (write_reg) begin
            wordline = 16'h0001 << dst_reg;
        end else begin
            wordline = 16'h0000;
        end
    end

endmodule

module reg_file_16x16 #(
    parameter int DATA_WIDTH = 16,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            src_reg1,
    input  logic [3:0]            src_reg2,
    input  logic [3:0]            dst_reg,
    input  logic                  write_reg,
    input  logic [DATA_WIDTH-1:0] dst_data,
    output logic [DATA_WIDTH-1:0] src_data1,
    output logic [DATA_WIDTH-1:0] src_data2
);

    localparam logic [15:0] ENTRY_MASK_C = (ZERO_REG != 0) ? 16'hFFFE : 16'hFFFF;

    logic [15:0]           wordline_s;
    logic [15:0]           entry_en_s;
    logic [DATA_WIDTH-1:0] regs_r [0:15];
    logic                  bypass_hit1_s;
    logic                  bypass_hit2_s;

    // Zero register wins over the bypass and over stored contents
    function automatic logic [DATA_WIDTH-1:0] resolve_read(
        input logic [3:0]            idx,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  bypass_hit,
        input logic [DATA_WIDTH-1:0] wr_data
    );
        logic [DATA_WIDTH-1:0] result;
        if ((ZERO_REG != 0) && (idx == 4'h0)) begin
            result = {DATA_WIDTH{1'b0}};
        end else if (bypass_hit) begin
            result = wr_data;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    reg_file_16x16_wr_dec u_wr_dec (
        .dst_reg   (dst_reg),
        .write_reg (write_reg),
        .wordline  (wordline_s)
    );

    assign entry_en_s = wordline_s & ENTRY_MASK_C;

    // Per-entry storage, cleared asynchronously, each loaded by its own enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (entry_en_s[i]) begin
                    regs_r[i] <= dst_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Bypass is suppressed during reset so reads stay zero while rst_n is low
    always_comb begin
        bypass_hit1_s = write_reg && rst_n && (dst_reg == src_reg1);
        bypass_hit2_s = write_reg && rst_n && (dst_reg == src_reg2);
    end
`else
    // Without bypass, reads always show stored contents
    always_comb begin
        bypass_hit1_s = 1'b0;
        bypass_hit2_s = 1'b0;
    end
`endif

    // Independent combinational read ports
    always_comb begin
        src_data1 = resolve_read(src_reg1, regs_r[src_reg1], bypass_hit1_s, dst_data);
        src_data2 = resolve_read(src_reg2, regs_r[src_reg2], bypass_hit2_s, dst_data);
    end

endmodule

// File: tb/tb_reg_file_16x16.sv
// Directed self-checking bench for reg_file_16x16 (ZERO_REG=1); expectations follow REGFILE_BYPASS_EN.

module tb_reg_file_16x16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  src_reg1;
    logic [3:0]  src_reg2;
    logic [3:0]  dst_reg;
    logic        write_reg;
    logic [15:0] dst_data;
    logic [15:0] src_data1;
    logic [15:0] src_data2;

    int n_checks;
    int n_errors;

    reg_file_16x16 #(
        .DATA_WIDTH (16),
        .ZERO_REG   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_reg1  (src_reg1),
        .src_reg2  (src_reg2),
        .dst_reg   (dst_reg),
        .write_reg (write_reg),
        .dst_data  (dst_data),
        .src_data1 (src_data1),
        .src_data2 (src_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    // Present a write after a falling edge; it lands on the following rising edge
    task automatic write_entry(input logic [3:0] idx, input logic [15:0] data);
        @(negedge clk);
        write_reg = 1'b1;
        dst_reg   = idx;
        dst_data  = data;
        @(negedge clk);
        write_reg = 1'b0;
    endtask

    logic [15:0] exp_bypass;
    logic [15:0] exp1;
    logic [15:0] exp2;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        write_reg = 1'b0;
        src_reg1  = 4'd0;
        src_reg2  = 4'd0;
        dst_reg   = 4'd0;
        dst_data  = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        src_reg1 = 4'd5;
        src_reg2 = 4'd15;
        #1;
        check_value("reset_r5", src_data1, 16'h0000);
        check_value("reset_r15", src_data2, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset clears storage without waiting for clk
        write_entry(4'd5, 16'h1234);
        src_reg1 = 4'd5;
        #1;
        check_value("pre_reset_r5", src_data1, 16'h1234);
        #1;
        rst_n = 1'b0;
        #1;
        check_value("async_reset_r5", src_data1, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read on consecutive edges
        @(negedge clk);
        write_reg = 1'b1;
        dst_reg   = 4'd3;
        dst_data  = 16'hA5A5;
        @(negedge clk);
        dst_reg   = 4'd12;
        dst_data  = 16'h5A5A;
        @(negedge clk);
        write_reg = 1'b0;
        src_reg1  = 4'd3;
        src_reg2  = 4'd12;
        #1;
        check_value("read_r3", src_data1, 16'hA5A5);
        check_value("read_r12", src_data2, 16'h5A5A);
        for (int k = 0; k < 16; k++) begin
            if (k != 3 && k != 12) begin
                src_reg2 = k[3:0];
                #1;
                check_value($sformatf("others_zero_r%0d", k), src_data2, 16'h0000);
            end
        end

        // Write gating: no request means no update, even with unknown dst_reg
        @(negedge clk);
        write_reg = 1'b0;
        dst_reg   = 4'd7;
        dst_data  = 16'hFFFF;
        repeat (4) @(negedge clk);
        dst_reg = 4'bxxxx;
        @(negedge clk);
        dst_reg  = 4'd0;
        src_reg1 = 4'd7;
        src_reg2 = 4'd3;
        #1;
        check_value("gated_r7", src_data1, 16'h0000);
        check_value("gated_r3_kept", src_data2, 16'hA5A5);
        src_reg2 = 4'd12;
        #1;
        check_value("xdst_r12_kept", src_data2, 16'h5A5A);

        // Zero register: same cycle and after the edge
        @(negedge clk);
        write_reg = 1'b1;
        dst_reg   = 4'd0;
        dst_data  = 16'hBEEF;
        src_reg1  = 4'd0;
        src_reg2  = 4'd0;
        #1;
        check_value("r0_same_cycle", src_data1, 16'h0000);
        @(negedge clk);
        write_reg = 1'b0;
        #1;
        check_value("r0_after_edge", src_data1, 16'h0000);

        // Bypass: per-port, only on the index being written
        write_entry(4'd9, 16'h0001);
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 16'h0002;
`else
        exp_bypass = 16'h0001;
`endif
        @(negedge clk);
        write_reg = 1'b1;
        dst_reg   = 4'd9;
        dst_data  = 16'h0002;
        src_reg1  = 4'd9;
        src_reg2  = 4'd9;
        #1;
        check_value("bypass_p1_pre", src_data1, exp_bypass);
        check_value("bypass_p2_pre", src_data2, exp_bypass);
        src_reg2 = 4'd3;
        #1;
        check_value("bypass_p2_other", src_data2, 16'hA5A5);
        @(negedge clk);
        write_reg = 1'b0;
        src_reg2  = 4'd9;
        #1;
        check_value("bypass_p1_post", src_data1, 16'h0002);
        check_value("bypass_p2_post", src_data2, 16'h0002);

        // Full sweep of pairs (k, 15-k)
        for (int k = 1; k < 16; k++) begin
            write_entry(k[3:0], 16'h1000 + 16'(k));
        end
        for (int k = 0; k < 16; k++) begin
            src_reg1 = k[3:0];
            src_reg2 = 4'(15 - k);
            exp1 = (k == 0) ? 16'h0000 : 16'h1000 + 16'(k);
            exp2 = (k == 15) ? 16'h0000 : 16'h1000 + 16'(15 - k);
            #1;
            check_value($sformatf("sweep_p1_r%0d", k), src_data1, exp1);
            check_value($sformatf("sweep_p2_r%0d", 15 - k), src_data2, exp2);
        end

        // Write presented in the cycle reset deasserts is accepted
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        write_reg = 1'b1;
        dst_reg   = 4'd6;
        dst_data  = 16'h00C6;
        src_reg1  = 4'd6;
        src_reg2  = 4'd6;
        #1;
        check_value("reset_blocks_bypass", src_data2, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        write_reg = 1'b0;
        src_reg2  = 4'd15;
        #1;
        check_value("write_at_reset_exit", src_data1, 16'h00C6);
        check_value("reset_cleared_r15", src_data2, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
